// File: rtl/decimal_keypad_pkg.sv
// Shared types and helpers for the decimal keypad debouncer.
// Holds the key-line width, the FSM state encoding and the one-hot test.
package decimal_keypad_pkg;

  localparam int KEY_W = 10;

  typedef logic [KEY_W-1:0] keys_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Exactly one bit set; clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input keys_t k);
    return (k != '0) && ((k & (k - keys_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/decimal_keypad_debouncer_key_sync.sv
// Two-flop synchronizer for asynchronous key lines.
// Each bit is synchronized independently; only the second flop is consumed.
module key_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // sample their inputs from before the edge; blocking here would collapse
  // the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/decimal_keypad_debouncer.sv
// Debounces a 10-line decimal keypad and emits a registered one-hot key code
// with single-cycle accept / multi-key-error pulses.
module decimal_keypad_debouncer
  import decimal_keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] keys_raw,
  output logic [KEY_W-1:0] decimal,
  output logic             key_valid,
  output logic             multi_key_err,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  keys_t            keys_s;
  keys_t            snap;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  key_sync #(
    .W (KEY_W)
  ) u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (keys_raw),
    .q     (keys_s)
  );

  // busy is registered alongside state so it changes on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      snap          <= '0;
      cnt           <= '0;
      decimal       <= '0;
      key_valid     <= 1'b0;
      multi_key_err <= 1'b0;
      busy          <= 1'b0;
    end else begin
      key_valid     <= 1'b0;
      multi_key_err <= 1'b0;

      case (state)
        IDLE: begin
          if (keys_s != '0) begin
            snap  <= keys_s;
            cnt   <= '0;
            state <= DEBOUNCE;
            busy  <= 1'b1;
          end
        end

        DEBOUNCE: begin
          if (keys_s == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (keys_s != snap) begin
            snap <= keys_s;
            cnt  <= '0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            // Stable long enough: accept a single key, flag chords.
            if (is_onehot(snap)) begin
              decimal   <= snap;
              key_valid <= 1'b1;
            end else begin
              multi_key_err <= 1'b1;
            end
            state <= PRESSED;
          end
        end

        PRESSED: begin
          if (keys_s == '0) begin
            cnt   <= '0;
            state <= RELEASE;
          end
        end

        RELEASE: begin
          if (keys_s != '0) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_pulse_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(key_valid && multi_key_err));

  a_valid_one_cycle : assert property (@(posedge clk) disable iff (!rst_n)
    key_valid |=> !key_valid);

  a_err_one_cycle : assert property (@(posedge clk) disable iff (!rst_n)
    multi_key_err |=> !multi_key_err);

  a_decimal_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    (decimal == '0) || is_onehot(decimal));

endmodule

// File: tb/tb_decimal_keypad_debouncer.sv
// Directed bench for decimal_keypad_debouncer with DEBOUNCE_CYCLES = 4.
// A negedge monitor counts pulses; the initial block checks against hand values.
module tb_decimal_keypad_debouncer;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] keys_raw;
  logic [9:0] decimal;
  logic       key_valid;
  logic       multi_key_err;
  logic       busy;

  int tests = 0;
  int fails = 0;

  int edge_cnt     = 0;
  int kv_cnt       = 0;
  int err_cnt      = 0;
  int last_kv_edge = -1;
  int wide_cnt     = 0;
  int both_cnt     = 0;
  int bad_dec_cnt  = 0;
  logic prev_kv    = 1'b0;
  logic prev_err   = 1'b0;

  int e1;
  int kv_base;
  int err_base;

  decimal_keypad_debouncer #(
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .keys_raw      (keys_raw),
    .decimal       (decimal),
    .key_valid     (key_valid),
    .multi_key_err (multi_key_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (key_valid) begin
      kv_cnt++;
      last_kv_edge = edge_cnt;
    end
    if (multi_key_err) err_cnt++;
    if (key_valid && prev_kv) wide_cnt++;
    if (multi_key_err && prev_err) wide_cnt++;
    if (key_valid && multi_key_err) both_cnt++;
    if (decimal != '0 && $countones(decimal) != 1) bad_dec_cnt++;
    prev_kv  = key_valid;
    prev_err = multi_key_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n falling edges, then step off the edge so monitor updates settle.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    keys_raw = '0;
    cycles(3);
    check("reset_decimal", 32'(decimal), 32'h0);
    check("reset_key_valid", 32'(key_valid), 32'h0);
    check("reset_multi_key_err", 32'(multi_key_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    cycles(3);
    check("idle_busy", 32'(busy), 32'h0);

    // Clean press of key 3.
    kv_base  = kv_cnt;
    keys_raw = 10'h008;
    e1       = edge_cnt + 1;
    cycles(20);
    check("clean_pulse_count", 32'(kv_cnt - kv_base), 32'd1);
    check("clean_latency_edge", 32'(last_kv_edge), 32'(e1 + 6));
    check("clean_decimal", 32'(decimal), 32'h008);
    check("clean_busy_held", 32'(busy), 32'h1);
    keys_raw = '0;
    cycles(10);
    check("clean_busy_released", 32'(busy), 32'h0);
    check("clean_decimal_hold", 32'(decimal), 32'h008);

    // Bounce on key 4, then a clean hold.
    kv_base = kv_cnt;
    for (int i = 0; i < 3; i++) begin
      keys_raw = 10'h010;
      cycles(2);
      keys_raw = '0;
      cycles(2);
    end
    check("bounce_no_pulse", 32'(kv_cnt - kv_base), 32'd0);
    keys_raw = 10'h010;
    e1       = edge_cnt + 1;
    cycles(20);
    check("bounce_pulse_count", 32'(kv_cnt - kv_base), 32'd1);
    check("bounce_latency_edge", 32'(last_kv_edge), 32'(e1 + 6));
    check("bounce_decimal", 32'(decimal), 32'h010);
    keys_raw = '0;
    cycles(10);

    // Two keys at once.
    kv_base  = kv_cnt;
    err_base = err_cnt;
    keys_raw = 10'h003;
    cycles(20);
    check("chord_err_count", 32'(err_cnt - err_base), 32'd1);
    check("chord_no_valid", 32'(kv_cnt - kv_base), 32'd0);
    check("chord_decimal_kept", 32'(decimal), 32'h010);
    keys_raw = '0;
    cycles(10);

    // Long hold of key 9, release, press again.
    kv_base  = kv_cnt;
    keys_raw = 10'h200;
    cycles(100);
    check("held_first_pulse", 32'(kv_cnt - kv_base), 32'd1);
    check("held_decimal", 32'(decimal), 32'h200);
    keys_raw = '0;
    cycles(10);
    keys_raw = 10'h200;
    cycles(20);
    check("held_two_pulses", 32'(kv_cnt - kv_base), 32'd2);

    // Short release glitch while pressed must not re-accept.
    kv_base  = kv_cnt;
    keys_raw = '0;
    cycles(2);
    keys_raw = 10'h200;
    cycles(20);
    check("glitch_no_pulse", 32'(kv_cnt - kv_base), 32'd0);
    check("glitch_busy", 32'(busy), 32'h1);
    keys_raw = '0;
    cycles(10);
    check("glitch_release_idle", 32'(busy), 32'h0);
    check("glitch_still_no_pulse", 32'(kv_cnt - kv_base), 32'd0);

    // Reset in the middle of debouncing key 3.
    keys_raw = 10'h008;
    cycles(4);
    check("midreset_busy_before", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_decimal", 32'(decimal), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_key_valid", 32'(key_valid), 32'h0);
    check("midreset_multi_key_err", 32'(multi_key_err), 32'h0);
    kv_base = kv_cnt;
    cycles(2);
    check("midreset_no_pulse", 32'(kv_cnt - kv_base), 32'd0);
    rst_n = 1'b1;
    e1    = edge_cnt + 1;
    cycles(20);
    check("midreset_pulse_count", 32'(kv_cnt - kv_base), 32'd1);
    check("midreset_latency_edge", 32'(last_kv_edge), 32'(e1 + 6));
    check("midreset_decimal_after", 32'(decimal), 32'h008);
    keys_raw = '0;
    cycles(10);

    check("pulse_width_violations", 32'(wide_cnt), 32'd0);
    check("pulse_overlap_violations", 32'(both_cnt), 32'd0);
    check("decimal_onehot_violations", 32'(bad_dec_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decimal_keypad_debouncer.md
DECIMAL_KEYPAD_DEBOUNCER -- requirements
Module: decimal_keypad_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable clocks required to accept a press or release; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state SHALL be on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port keys_raw, input, 10 bits, asynchronous mechanical key lines, bit k high while decimal key k is pressed.
REQ-005 The block SHALL have port decimal, output, 10 bits, the registered one-hot code of the last accepted key, feeding the downstream decimal-to-binary encoder.
REQ-006 The block SHALL have port key_valid, output, 1 bit, a one-clock pulse in the cycle that decimal takes a newly accepted value.
REQ-007 The block SHALL have port multi_key_err, output, 1 bit, a one-clock pulse when a debounced press has more than one bit set.
REQ-008 The block SHALL have port busy, output, 1 bit, high in every state other than IDLE.

Function
REQ-009 keys_raw SHALL pass through a two-flop synchronizer with reset value 0; the second flop output is keys_s, and only keys_s is used.
REQ-010 The FSM SHALL have four states: IDLE, DEBOUNCE, PRESSED, RELEASE; the debounce counter width SHALL be clog2(DEBOUNCE_CYCLES).
REQ-011 IDLE: if keys_s != 0, the block SHALL load snap <= keys_s, clear cnt and go to DEBOUNCE; otherwise it SHALL stay in IDLE.
REQ-012 DEBOUNCE, keys_s == 0: the block SHALL go to IDLE with no pulse.
REQ-013 DEBOUNCE, keys_s != snap and nonzero: the block SHALL reload snap and clear cnt, restarting the count.
REQ-014 DEBOUNCE, keys_s == snap and cnt < DEBOUNCE_CYCLES-1: the block SHALL increment cnt.
REQ-015 DEBOUNCE, keys_s == snap and cnt == DEBOUNCE_CYCLES-1: if snap is one-hot, the block SHALL register decimal <= snap and pulse key_valid; otherwise it SHALL pulse multi_key_err and leave decimal unchanged; in both cases it SHALL go to PRESSED.
REQ-016 PRESSED: if keys_s == 0, the block SHALL clear cnt and go to RELEASE; any nonzero change SHALL be ignored, so at most one accept occurs per press.
REQ-017 RELEASE: if keys_s != 0, the block SHALL return to PRESSED; otherwise it SHALL increment cnt and go to IDLE when cnt == DEBOUNCE_CYCLES-1.
REQ-018 Latency: with keys_raw stable from the first sampling edge E1, key_valid SHALL be high after edge E(DEBOUNCE_CYCLES+3), including 2 synchronizer edges and 1 IDLE edge.
REQ-019 key_valid and multi_key_err SHALL never be high in the same cycle, and each SHALL be exactly one cycle wide.
REQ-020 decimal SHALL hold its value until the next accepted key; it SHALL be 0 or one-hot at all times.

Reset
REQ-021 While rst_n = 0, the block SHALL force state = IDLE, the synchronizer flops, snap, cnt, decimal, key_valid, multi_key_err and busy all to 0, regardless of clk.
REQ-022 On reset mid-press, the block SHALL restart from IDLE after release and re-debounce the held key in full, with no pulse during reset.

Structure
REQ-023 A shared package decimal_keypad_pkg SHALL hold KEY_W = 10, the state enum, and a one-hot check function.
REQ-024 The synchronizer SHALL be one sub-module, key_sync, parameterised by width, with an asynchronous active-low reset.

Verification (DEBOUNCE_CYCLES = 4)
REQ-025 Clean press: hold keys_raw = 10'h008 for 20 cycles -> exactly one key_valid pulse, after edge 7; decimal = 10'h008.
REQ-026 Bounce: toggle keys_raw between 10'h010 and 0 every 2 cycles for 12 cycles, then hold 10'h010 -> no pulse during toggling; one key_valid 7 edges after the final hold; decimal = 10'h010.
REQ-027 Two keys: hold 10'h003 for 20 cycles -> one multi_key_err pulse, no key_valid, decimal unchanged from its prior value.
REQ-028 Held key: hold 10'h200 for 100 cycles, release for 10, press 10'h200 again -> exactly two key_valid pulses.
REQ-029 Release glitch: in PRESSED, drop keys to 0 for 2 cycles then restore -> no new pulse; state returns to PRESSED.
REQ-030 Reset mid-DEBOUNCE: assert rst_n = 0 asynchronously -> outputs 0 immediately; after rst_n = 1 with the key still held, key_valid follows 7 edges later.
